// File: rtl/audio_pkg.sv
// Shared definitions for the DSD audio DAC: register map, CTRL/STATUS bit
// positions and sample format.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] SAMPLE_SIGN_FLIP = 16'h8000;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DIV    = 2'd2,
    REG_CTRL   = 2'd3
  } reg_sel_e;

  localparam int CTRL_ENABLE_BIT       = 0;
  localparam int CTRL_CLR_UNDERRUN_BIT = 1;

  localparam int STAT_LEVEL_MSB    = 7;
  localparam int STAT_EMPTY_BIT    = 8;
  localparam int STAT_FULL_BIT     = 9;
  localparam int STAT_UNDERRUN_BIT = 10;

  // Builds a 16-bit value from the strobed low two bytes of a bus word;
  // unstrobed bytes come out as zero.
  function automatic logic [15:0] strobe_low16(input logic [31:0] data,
                                               input logic [1:0]  strb);
    logic [15:0] v;
    v = '0;
    if (strb[0]) v[7:0]  = data[7:0];
    if (strb[1]) v[15:8] = data[15:8];
    return v;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with occupancy level; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module audio_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [7:0]       o_level,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_level == LW'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_level    = 8'(r_level);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/audio_dsd_dac.sv
// Bus-attached 1-bit sigma-delta audio DAC: register decode, sample-rate
// divider, sample FIFO and first-order modulator.
module audio_dsd_dac
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 562
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        dsd
);

  // Handshake: a transfer is taken in any cycle with sel high and ready low.
  // ready is a single-cycle pulse registered off the accepting cycle, so it
  // can never repeat back-to-back; a DATA push into a full FIFO simply is not
  // accepted until a pop makes room, and the master keeps sel high meanwhile.
  logic                r_ready;
  logic [31:0]         r_rdata;
  logic                r_dsd;
  logic [15:0]         r_div;
  logic                r_enable;
  logic                r_underrun;
  logic [15:0]         r_div_cnt;
  logic [SAMPLE_W-1:0] r_sample;
  logic [SAMPLE_W:0]   r_acc;

  reg_sel_e            w_reg;
  logic                w_take;
  logic                w_write;
  logic                w_data_push_req;
  logic                w_stall;
  logic                w_complete;
  logic                w_div_wr;
  logic                w_ctrl_wr;
  logic                w_clr_underrun;
  logic [15:0]         w_div_eff;
  logic                w_tick;
  logic                w_pop;
  logic                w_underrun_evt;
  logic                w_fifo_push;
  logic [SAMPLE_W-1:0] w_push_data;
  logic [SAMPLE_W-1:0] w_fifo_head;
  logic [7:0]          w_fifo_level;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [31:0]         w_rd_val;
  logic                w_unused;

  assign w_reg   = reg_sel_e'(addr[3:2]);
  assign w_take  = sel && !r_ready;
  assign w_write = |wstrb;

  assign w_data_push_req = w_take && w_write && (w_reg == REG_DATA) && (wstrb[0] || wstrb[1]);
  assign w_stall         = w_data_push_req && w_fifo_full && !w_pop;
  assign w_fifo_push     = w_data_push_req && !w_stall;
  assign w_complete      = w_take && !w_stall;
  assign w_push_data     = strobe_low16(wdata, wstrb[1:0]);

  assign w_div_wr       = w_complete && w_write && (w_reg == REG_DIV);
  assign w_ctrl_wr      = w_complete && w_write && (w_reg == REG_CTRL);
  assign w_clr_underrun = w_ctrl_wr && wstrb[0] && wdata[CTRL_CLR_UNDERRUN_BIT];

  // Divide ratios below 2 would tick every cycle or never; both run as 2.
  assign w_div_eff      = (r_div < 16'd2) ? 16'd2 : r_div;
  assign w_tick         = r_enable && (r_div_cnt == (w_div_eff - 16'd1));
  assign w_pop          = w_tick && !w_fifo_empty;
  assign w_underrun_evt = w_tick && w_fifo_empty;

  assign w_unused = ^{addr[23:4], addr[1:0], wdata[31:16]};

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_fifo_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_head),
    .o_level     (w_fifo_level),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_comb begin
    w_rd_val = '0;
    case (w_reg)
      REG_STATUS: begin
        w_rd_val[STAT_LEVEL_MSB:0]  = w_fifo_level;
        w_rd_val[STAT_EMPTY_BIT]    = w_fifo_empty;
        w_rd_val[STAT_FULL_BIT]     = w_fifo_full;
        w_rd_val[STAT_UNDERRUN_BIT] = r_underrun;
      end
      REG_DIV:  w_rd_val[15:0] = r_div;
      REG_CTRL: w_rd_val[CTRL_ENABLE_BIT] = r_enable;
      default:  w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_complete;
      r_rdata <= (w_complete && !w_write) ? w_rd_val : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= 16'(DIV_RESET);
      r_enable   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_div_wr && wstrb[0]) r_div[7:0]  <= wdata[7:0];
      if (w_div_wr && wstrb[1]) r_div[15:8] <= wdata[15:8];
      if (w_ctrl_wr && wstrb[0]) r_enable <= wdata[CTRL_ENABLE_BIT];
      // A same-cycle underrun outranks the clear request.
      if (w_underrun_evt)      r_underrun <= 1'b1;
      else if (w_clr_underrun) r_underrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (!r_enable || w_div_wr || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  // Disabled output sits at mid-scale; an empty FIFO on a tick holds the sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample <= '0;
    end else if (!r_enable) begin
      r_sample <= '0;
    end else if (w_pop) begin
      r_sample <= w_fifo_head;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_dsd <= 1'b0;
    end else begin
      r_acc <= {1'b0, r_acc[SAMPLE_W-1:0]} + {1'b0, r_sample ^ SAMPLE_SIGN_FLIP};
      r_dsd <= r_acc[SAMPLE_W];
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;
  assign dsd   = r_dsd;

endmodule

// File: tb/tb_audio_dsd_dac.sv
// Self-checking bench for audio_dsd_dac: bus transfers, FIFO flow control,
// divider/underrun timing and modulator output patterns.
module tb_audio_dsd_dac;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;
  localparam int         DEPTH    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        ready;
  logic [3:0]  wstrb = 4'd0;
  logic [23:0] addr = 24'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        dsd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] exp_q[$];

  audio_dsd_dac #(.FIFO_DEPTH(DEPTH), .DIV_RESET(562)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .ready (ready),
    .wstrb (wstrb),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .dsd   (dsd)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sel   = 1'b0;
    wstrb = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ready must be a lone pulse answering a sel sampled high at that edge
  logic sel_q = 1'b0;
  logic prev_ready = 1'b0;
  always @(posedge clk) sel_q <= sel;
  always @(negedge clk) begin
    if (ready) begin
      n_tests++;
      if (prev_ready || !sel_q) begin
        n_fail++;
        $display("FAIL ready_pulse: ready=1 prev_ready=%0b sel_at_edge=%0b, required lone pulse after sel", prev_ready, sel_q);
      end
    end
    prev_ready = ready;
  end

  // ---------------- driver ----------------
  task automatic bus_xfer(input logic [1:0] reg_idx, input logic [3:0] strb,
                          input logic [31:0] data, input int budget,
                          output logic [31:0] rd, output int cap_edge, output int lat);
    logic got;
    @(negedge clk);
    sel = 1'b1; addr = {20'd0, reg_idx, 2'b00}; wstrb = strb; wdata = data;
    got = 1'b0; rd = '0; cap_edge = -1; lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1; rd = rdata; cap_edge = cyc; lat = i + 1;
        break;
      end
    end
    sel = 1'b0; wstrb = 4'd0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL bus_timeout: reg=%0d no ready within %0d cycles", reg_idx, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd; int cap, lat;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ready !== 1'b0 || rdata !== 32'd0 || dsd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rdata=%h dsd=%b, required 0/0/0", ready, rdata, dsd);
    end
    reset = 1'b0;
    bus_xfer(A_STATUS, 4'd0, 32'd0, 10, rd, cap, lat);
    n_tests++;
    if (rd !== 32'h0000_0100 || lat !== 1) begin
      n_fail++;
      $display("FAIL reset_status: rdata=%h lat=%0d, required 00000100 lat=1", rd, lat);
    end
    bus_xfer(A_DIV, 4'd0, 32'd0, 10, rd, cap, lat);
    n_tests++;
    if (rd !== 32'd562 || lat !== 1) begin
      n_fail++;
      $display("FAIL reset_div: rdata=%0d lat=%0d, required 562 lat=1", rd, lat);
    end
    bus_xfer(A_CTRL, 4'd0, 32'd0, 10, rd, cap, lat);
    n_tests++;
    if (rd !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdata=%h, required 0", rd);
    end
  endtask

  task automatic test_pop_timing();
    logic [31:0] rd, exp; int cap, lat, en_edge, t, pops, hi;
    do_reset();
    bus_xfer(A_DIV, 4'b0011, 32'd4, 10, rd, cap, lat);
    repeat (3) bus_xfer(A_DATA, 4'b0011, 32'h0000_7FFF, 10, rd, cap, lat);
    bus_xfer(A_STATUS, 4'd0, 32'd0, 10, rd, cap, lat);
    n_tests++;
    if (rd !== 32'h0000_0003) begin
      n_fail++;
      $display("FAIL pop_pre_level: rdata=%h, required 00000003", rd);
    end
    bus_xfer(A_CTRL, 4'b0001, 32'd1, 10, rd, en_edge, lat);
    // ticks at en_edge + 4k; a read sees the state left by the previous edge
    for (int k = 0; k < 10; k++) begin
      bus_xfer(A_STATUS, 4'd0, 32'd0, 10, rd, cap, lat);
      t    = cap - en_edge;
      pops = (t - 1) / 4;
      if (pops > 3) pops = 3;
      exp  = 32'(3 - pops);
      if (pops == 3) exp[8] = 1'b1;
      if (t - 1 >= 16) exp[10] = 1'b1;
      n_tests++;
      if (rd !== exp || lat !== 1) begin
        n_fail++;
        $display("FAIL pop_level t=%0d: rdata=%h lat=%0d, required %h lat=1", t, rd, lat, exp);
      end
    end
    hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (dsd === 1'b1) hi++;
    end
    n_tests++;
    if (hi < 198) begin
      n_fail++;
      $display("FAIL pop_duty: dsd high %0d of 200, required >=198", hi);
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] rd; int cap, lat, en_edge, d;
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      bus_xfer(A_DATA, 4'b0011, $urandom, 10, rd, cap, lat);
    bus_xfer(A_STATUS, 4'd0, 32'd0, 10, rd, cap, lat);
    n_tests++;
    if (rd !== 32'h0000_0210) begin
      n_fail++;
      $display("FAIL full_status: rdata=%h, required 00000210", rd);
    end
    d = $urandom_range(10, 30);
    bus_xfer(A_DIV, 4'b0011, 32'(d), 10, rd, cap, lat);
    bus_xfer(A_CTRL, 4'b0001, 32'd1, 10, rd, en_edge, lat);
    bus_xfer(A_DATA, 4'b0011, $urandom, 100, rd, cap, lat);
    n_tests++;
    if (cap !== en_edge + d) begin
      n_fail++;
      $display("FAIL full_stall_ready: ready at edge %0d, required %0d (first tick)", cap, en_edge + d);
    end
    bus_xfer(A_STATUS, 4'd0, 32'd0, 10, rd, cap, lat);
    n_tests++;
    if (rd !== 32'h0000_0210) begin
      n_fail++;
      $display("FAIL full_after_push: rdata=%h, required 00000210", rd);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] rd, exp; int cap, lat, en_edge, c1, c2, nxt;
    logic u;
    do_reset();
    bus_xfer(A_DIV, 4'b0011, 32'($urandom_range(0, 2)), 10, rd, cap, lat);
    bus_xfer(A_CTRL, 4'b0001, 32'd1, 10, rd, en_edge, lat);
    repeat (4) @(negedge clk);
    bus_xfer(A_STATUS, 4'd0, 32'd0, 10, rd, cap, lat);
    n_tests++;
    if (rd !== 32'h0000_0500) begin
      n_fail++;
      $display("FAIL underrun_set: rdata=%h, required 00000500", rd);
    end
    // ticks every 2 edges after enable; set beats clear on a shared edge
    bus_xfer(A_CTRL, 4'b0001, 32'd3, 10, rd, c1, lat);
    bus_xfer(A_STATUS, 4'd0, 32'd0, 10, rd, cap, lat);
    nxt = (((c1 - en_edge) % 2) == 0) ? c1 : c1 + 1;
    u   = (nxt <= cap - 1);
    exp = 32'h0000_0100 | (32'(u) << 10);
    n_tests++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL underrun_clear_en: rdata=%h, required %h", rd, exp);
    end
    bus_xfer(A_CTRL, 4'b0001, 32'd2, 10, rd, c2, lat);
    u   = (((c2 - en_edge) % 2) == 0);
    exp = 32'h0000_0100 | (32'(u) << 10);
    bus_xfer(A_STATUS, 4'd0, 32'd0, 10, rd, cap, lat);
    n_tests++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL underrun_clear_dis: rdata=%h, required %h", rd, exp);
    end
    bus_xfer(A_CTRL, 4'd0, 32'd0, 10, rd, cap, lat);
    n_tests++;
    if (rd !== 32'd0) begin
      n_fail++;
      $display("FAIL ctrl_selfclear: rdata=%h, required 0", rd);
    end
  endtask

  task automatic test_dsd_patterns();
    logic [31:0] rd; int cap, lat, bad; logic p;
    do_reset();
    bus_xfer(A_DATA, 4'b0011, 32'h0000_0000, 10, rd, cap, lat);
    bus_xfer(A_DIV, 4'b0011, 32'd2, 10, rd, cap, lat);
    bus_xfer(A_CTRL, 4'b0001, 32'd1, 10, rd, cap, lat);
    repeat (10) @(negedge clk);
    p = dsd; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (dsd === p) bad++;
      p = dsd;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL dsd_midscale: %0d non-toggling cycles of 20, required 0", bad);
    end
    do_reset();
    bus_xfer(A_DATA, 4'b0011, 32'h0000_8000, 10, rd, cap, lat);
    bus_xfer(A_DIV, 4'b0011, 32'd2, 10, rd, cap, lat);
    bus_xfer(A_CTRL, 4'b0001, 32'd1, 10, rd, cap, lat);
    repeat (10) @(negedge clk);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (dsd !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL dsd_negfull: dsd high %0d of 50 cycles, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] rd; int cap, lat, seen;
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      bus_xfer(A_DATA, 4'b0011, $urandom, 10, rd, cap, lat);
    @(negedge clk);
    sel = 1'b1; addr = {20'd0, A_DATA, 2'b00}; wstrb = 4'b0011; wdata = 32'h1234;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready !== 1'b0) seen++;
    end
    reset = 1'b1;
    @(negedge clk);
    if (ready !== 1'b0) seen++;
    sel = 1'b0; wstrb = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL stall_no_ready: ready seen %0d times, required 0", seen);
    end
    bus_xfer(A_STATUS, 4'd0, 32'd0, 10, rd, cap, lat);
    n_tests++;
    if (rd !== 32'h0000_0100 || lat !== 1) begin
      n_fail++;
      $display("FAIL stall_reset_status: rdata=%h lat=%0d, required 00000100 lat=1", rd, lat);
    end
  endtask

  task automatic test_regs_random();
    logic [31:0] rd, d, exp; logic [3:0] s; logic [15:0] m_div;
    int cap, lat, op, m_level;
    do_reset();
    m_div = 16'd562; m_level = 0;
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 4);
      d  = $urandom;
      s  = 4'($urandom_range(1, 15));
      if (op == 0 && m_level < DEPTH) begin
        bus_xfer(A_DATA, s, d, 10, rd, cap, lat);
        if (s[1:0] != 2'b00) m_level++;
        n_tests++;
        if (lat !== 1) begin
          n_fail++;
          $display("FAIL rnd_push_lat: lat=%0d, required 1", lat);
        end
      end else if (op == 1 || op == 0) begin
        exp_q.push_back(32'(m_level) | (32'(m_level == 0) << 8) | (32'(m_level == DEPTH) << 9));
        bus_xfer(A_STATUS, 4'd0, 32'd0, 10, rd, cap, lat);
        exp = exp_q.pop_front();
        n_tests++;
        if (rd !== exp) begin
          n_fail++;
          $display("FAIL rnd_status: rdata=%h, required %h", rd, exp);
        end
      end else if (op == 2) begin
        bus_xfer(A_DIV, s, d, 10, rd, cap, lat);
        if (s[0]) m_div[7:0]  = d[7:0];
        if (s[1]) m_div[15:8] = d[15:8];
      end else if (op == 3) begin
        exp_q.push_back({16'd0, m_div});
        bus_xfer(A_DIV, 4'd0, 32'd0, 10, rd, cap, lat);
        exp = exp_q.pop_front();
        n_tests++;
        if (rd !== exp) begin
          n_fail++;
          $display("FAIL rnd_div: rdata=%h, required %h", rd, exp);
        end
      end else begin
        bus_xfer(A_CTRL, s, d & 32'hFFFF_FFFE, 10, rd, cap, lat);
        bus_xfer(A_CTRL, 4'd0, 32'd0, 10, rd, cap, lat);
        n_tests++;
        if (rd !== 32'd0) begin
          n_fail++;
          $display("FAIL rnd_ctrl: rdata=%h, required 0", rd);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_pop_timing();
    test_full_stall();
    test_underrun();
    test_dsd_patterns();
    test_reset_mid_stall();
    test_regs_random();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
